// File: rtl/multdiv_pkg.sv
// Shared types and op-class helpers for the multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [3:0] {
    OpNop,
    OpMult,
    OpMultu,
    OpMadd,
    OpMaddu,
    OpMsub,
    OpMsubu,
    OpDiv,
    OpDivu,
    OpMthi,
    OpMtlo
  } md_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAcc,
    StDone
  } md_state_t;

  // Ops whose product is folded into HI/LO rather than written directly.
  function automatic logic is_acc(md_op_t op);
    return op inside {OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_sub(md_op_t op);
    return op inside {OpMsub, OpMsubu};
  endfunction

  // Ops that occupy the multiply/divide unit.
  function automatic logic is_md(md_op_t op);
    return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu, OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// EXE-side request, unit handshake and HI/LO outputs of the multdiv sequencer.
// The master modport is the environment (EXE stage plus the arithmetic unit).
interface multdiv_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  import multdiv_pkg::*;

  logic              req_valid;
  md_op_t            req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              flush;
  logic              unit_start;
  md_op_t            unit_op;
  logic [DATA_W-1:0] unit_a;
  logic [DATA_W-1:0] unit_b;
  logic              unit_abort;
  logic              unit_done;
  logic [DATA_W-1:0] unit_hi;
  logic [DATA_W-1:0] unit_lo;
  logic              stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, unit_done, unit_hi, unit_lo,
    input  unit_start, unit_op, unit_a, unit_b, unit_abort, stall, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, unit_done, unit_hi, unit_lo,
    output unit_start, unit_op, unit_a, unit_b, unit_abort, stall, hi, lo
  );

endinterface

// File: rtl/hilo_acc.sv
// Combinational {HI,LO} +/- product for MADD/MSUB; wraps modulo 2^Width.
module hilo_acc #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] hilo_i,
  input  logic [Width-1:0] prod_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o
);

  // Add or subtract the captured product.
  always_comb begin
    sum_o = sub_i ? (hilo_i - prod_i) : (hilo_i + prod_i);
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer and HI/LO owner for the EXE-stage multiply/divide unit.
module multdiv_ctrl import multdiv_pkg::*; #(
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  multdiv_ctrl_if.slave bus
);

  md_state_t           state_q, state_d;
  md_op_t              op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] acc_sum;
  logic                md_req;
  logic                start;
  logic                abort;

  assign md_req = bus.req_valid && is_md(bus.req_op);

  hilo_acc #(
    .Width(2 * DATA_W)
  ) u_acc (
    .hilo_i({hi_q, lo_q}),
    .prod_i(prod_q),
    .sub_i (is_sub(op_q)),
    .sum_o (acc_sum)
  );

  // Next-state, operand latch and HI/LO write selection; flush overrides everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    start   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Reset is folded in so the combinational outputs read as idle while held.
        if (!bus.flush && rst) begin
          if (md_req) begin
            op_d    = bus.req_op;
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            start   = 1'b1;
            state_d = StBusy;
          end else if (bus.req_valid && bus.req_op == OpMthi) begin
            hi_d = bus.req_a;
          end else if (bus.req_valid && bus.req_op == OpMtlo) begin
            lo_d = bus.req_a;
          end
        end
      end
      StBusy: begin
        if (bus.flush) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else if (bus.unit_done) begin
          if (is_acc(op_q)) begin
            prod_d  = {bus.unit_hi, bus.unit_lo};
            state_d = StAcc;
          end else begin
            hi_d    = bus.unit_hi;
            lo_d    = bus.unit_lo;
            state_d = StDone;
          end
        end
      end
      StAcc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          {hi_d, lo_d} = acc_sum;
          state_d      = StDone;
        end
      end
      StDone: begin
        // The finished instruction is still presented this cycle; do not relaunch it.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand and architectural register update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
    end
  end

  // Output drive; stall covers the issue cycle and the whole unit occupancy.
  always_comb begin
    bus.unit_start = start;
    bus.unit_abort = abort;
    bus.unit_op    = op_q;
    bus.unit_a     = a_q;
    bus.unit_b     = b_q;
    bus.hi         = hi_q;
    bus.lo         = lo_q;
    bus.stall      = start || (state_q == StBusy) || (state_q == StAcc);
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   stall_cnt;
  int   start_cnt;
  int   abort_cnt;
  int   s0, st0, ab0;

  multdiv_ctrl_if #(.DATA_W(32)) bus ();

  multdiv_ctrl #(
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled at the active edge (inputs move 1 time unit later).
  always @(posedge clk) begin
    if (bus.stall)      stall_cnt <= stall_cnt + 1;
    if (bus.unit_start) start_cnt <= start_cnt + 1;
    if (bus.unit_abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input md_op_t op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
  endtask

  task automatic done(input logic d, input logic [31:0] h, input logic [31:0] l);
    bus.unit_done = d;
    bus.unit_hi   = h;
    bus.unit_lo   = l;
  endtask

  task automatic snap();
    s0  = stall_cnt;
    st0 = start_cnt;
    ab0 = abort_cnt;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    stall_cnt = 0; start_cnt = 0; abort_cnt = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, OpNop, 32'h0, 32'h0);
    done(1'b0, 32'h0, 32'h0);
    repeat (3) tick();

    // Reset state
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_stall", 64'(bus.stall), 64'h0);
    check("rst_start", 64'(bus.unit_start), 64'h0);
    check("rst_abort", 64'(bus.unit_abort), 64'h0);
    check("rst_op", 64'(bus.unit_op), 64'(OpNop));
    check("rst_a", 64'(bus.unit_a), 64'h0);
    check("rst_b", 64'(bus.unit_b), 64'h0);
    rst_n = 1'b1;
    tick();

    // MULT, 1-cycle unit
    snap();
    drive(1'b1, OpMult, 32'hFFFF_FFFE, 32'h3);
    #1;
    check("mult_issue_stall", 64'(bus.stall), 64'h1);
    check("mult_issue_start", 64'(bus.unit_start), 64'h1);
    tick();
    check("mult_unit_a", 64'(bus.unit_a), 64'hFFFF_FFFE);
    check("mult_unit_b", 64'(bus.unit_b), 64'h3);
    check("mult_unit_op", 64'(bus.unit_op), 64'(OpMult));
    check("mult_busy_start", 64'(bus.unit_start), 64'h0);
    done(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    tick();
    done(1'b0, 32'h0, 32'h0);
    check("mult_done_stall", 64'(bus.stall), 64'h0);
    check("mult_done_start", 64'(bus.unit_start), 64'h0);
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);
    drive(1'b0, OpNop, 32'h0, 32'h0);
    tick();
    check("mult_stall_cycles", 64'(stall_cnt - s0), 64'd2);
    check("mult_start_pulses", 64'(start_cnt - st0), 64'd1);

    // Preload HI=0, LO=FFFFFFFF through MTHI/MTLO
    drive(1'b1, OpMthi, 32'h0, 32'h0);
    #1;
    check("mthi_stall", 64'(bus.stall), 64'h0);
    tick();
    drive(1'b1, OpMtlo, 32'hFFFF_FFFF, 32'h0);
    tick();
    check("pre_lo", 64'(bus.lo), 64'hFFFF_FFFF);

    // MADDU with product 1: carry crosses into HI
    snap();
    drive(1'b1, OpMaddu, 32'h1, 32'h1);
    tick();
    done(1'b1, 32'h0, 32'h1);
    tick();
    done(1'b0, 32'h0, 32'h0);
    check("madd_acc_stall", 64'(bus.stall), 64'h1);
    check("madd_acc_hi_unch", 64'(bus.hi), 64'h0);
    tick();
    check("madd_done_stall", 64'(bus.stall), 64'h0);
    check("madd_hi", 64'(bus.hi), 64'h1);
    check("madd_lo", 64'(bus.lo), 64'h0);
    drive(1'b0, OpNop, 32'h0, 32'h0);
    tick();
    check("madd_stall_cycles", 64'(stall_cnt - s0), 64'd3);

    // MSUB with product 2: borrow back out of HI
    drive(1'b1, OpMsub, 32'h2, 32'h1);
    tick();
    done(1'b1, 32'h0, 32'h2);
    tick();
    done(1'b0, 32'h0, 32'h0);
    tick();
    check("msub_hi", 64'(bus.hi), 64'h0);
    check("msub_lo", 64'(bus.lo), 64'hFFFF_FFFE);
    drive(1'b0, OpNop, 32'h0, 32'h0);
    tick();

    // DIVU, unit_done 36 cycles after issue; request held through DONE
    snap();
    drive(1'b1, OpDivu, 32'd23, 32'd3);
    tick();
    repeat (35) tick();
    check("divu_op_stable", 64'(bus.unit_op), 64'(OpDivu));
    check("divu_a_stable", 64'(bus.unit_a), 64'd23);
    done(1'b1, 32'h2, 32'h7);
    tick();
    done(1'b0, 32'h0, 32'h0);
    check("divu_done_stall", 64'(bus.stall), 64'h0);
    check("divu_no_relaunch", 64'(bus.unit_start), 64'h0);
    check("divu_hi", 64'(bus.hi), 64'h2);
    check("divu_lo", 64'(bus.lo), 64'h7);
    drive(1'b0, OpNop, 32'h0, 32'h0);
    tick();
    check("divu_stall_cycles", 64'(stall_cnt - s0), 64'd37);
    check("divu_start_pulses", 64'(start_cnt - st0), 64'd1);

    // DIV flushed in BUSY cycle 5; a late unit_done is ignored
    snap();
    drive(1'b1, OpDiv, 32'd100, 32'd7);
    tick();
    repeat (4) tick();
    bus.flush = 1'b1;
    drive(1'b0, OpNop, 32'h0, 32'h0);
    #1;
    check("flush_abort", 64'(bus.unit_abort), 64'h1);
    tick();
    bus.flush = 1'b0;
    check("flush_idle", 64'(dut.state_q), 64'(StIdle));
    check("flush_abort_clr", 64'(bus.unit_abort), 64'h0);
    repeat (2) tick();
    done(1'b1, 32'hDEAD, 32'hBEEF);
    tick();
    done(1'b0, 32'h0, 32'h0);
    check("flush_hi", 64'(bus.hi), 64'h2);
    check("flush_lo", 64'(bus.lo), 64'h7);
    check("flush_abort_pulses", 64'(abort_cnt - ab0), 64'd1);
    check("flush_late_idle", 64'(dut.state_q), 64'(StIdle));

    // Flush coincident with unit_done
    drive(1'b1, OpMult, 32'h5, 32'h5);
    tick();
    drive(1'b0, OpNop, 32'h0, 32'h0);
    bus.flush = 1'b1;
    done(1'b1, 32'h0, 32'd25);
    tick();
    bus.flush = 1'b0;
    done(1'b0, 32'h0, 32'h0);
    check("flushdone_hi", 64'(bus.hi), 64'h2);
    check("flushdone_lo", 64'(bus.lo), 64'h7);
    check("flushdone_idle", 64'(dut.state_q), 64'(StIdle));

    // Flush during ACC
    drive(1'b1, OpMadd, 32'h5, 32'h1);
    tick();
    done(1'b1, 32'h0, 32'h5);
    tick();
    done(1'b0, 32'h0, 32'h0);
    drive(1'b0, OpNop, 32'h0, 32'h0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flushacc_hi", 64'(bus.hi), 64'h2);
    check("flushacc_lo", 64'(bus.lo), 64'h7);
    check("flushacc_idle", 64'(dut.state_q), 64'(StIdle));

    // No launch in an IDLE flush cycle
    snap();
    drive(1'b1, OpMult, 32'h9, 32'h9);
    bus.flush = 1'b1;
    #1;
    check("flushidle_start", 64'(bus.unit_start), 64'h0);
    check("flushidle_stall", 64'(bus.stall), 64'h0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, OpNop, 32'h0, 32'h0);
    check("flushidle_state", 64'(dut.state_q), 64'(StIdle));
    check("flushidle_pulses", 64'(start_cnt - st0), 64'd0);

    // Asynchronous reset mid-BUSY, request still presented
    drive(1'b1, OpMultu, 32'd11, 32'd22);
    tick();
    check("rstbusy_a", 64'(bus.unit_a), 64'd11);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_stall", 64'(bus.stall), 64'h0);
    check("arst_start", 64'(bus.unit_start), 64'h0);
    check("arst_abort", 64'(bus.unit_abort), 64'h0);
    check("arst_hi", 64'(bus.hi), 64'h0);
    check("arst_lo", 64'(bus.lo), 64'h0);
    check("arst_op", 64'(bus.unit_op), 64'(OpNop));
    check("arst_a", 64'(bus.unit_a), 64'h0);
    check("arst_b", 64'(bus.unit_b), 64'h0);
    check("arst_state", 64'(dut.state_q), 64'(StIdle));
    drive(1'b0, OpNop, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // MTHI / MTLO after reset
    drive(1'b1, OpMthi, 32'h1234, 32'h0);
    #1;
    check("mthi2_stall", 64'(bus.stall), 64'h0);
    tick();
    drive(1'b1, OpMtlo, 32'h5678, 32'h0);
    #1;
    check("mtlo2_stall", 64'(bus.stall), 64'h0);
    tick();
    drive(1'b0, OpNop, 32'h0, 32'h0);
    check("mt_hi", 64'(bus.hi), 64'h1234);
    check("mt_lo", 64'(bus.lo), 64'h5678);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
